// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the two-requester add/sub arbiter.
//   state_t  : holding-register FSM encoding (EMPTY / FULL)
//   REQ0/REQ1: requester index constants, also used as rsp_id values
package addsub_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/addsub_cla.sv
// W-bit carry-lookahead adder/subtractor (combinational).
// Ports:
//   a, b : W-bit operands
//   m    : mode, 0 = a+b, 1 = a-b (two's complement: b inverted, carry-in 1)
//   s    : W-bit result
//   co   : carry out of bit W-1
//   v    : signed overflow = carry into bit W-1 xor carry out of bit W-1
module addsub_cla #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic [W-1:0] s,
    output logic         co,
    output logic         v
);

    logic [W-1:0] bx_s;
    logic [W-1:0] p_s;
    logic [W-1:0] g_s;
    logic [W:0]   carry_s;

    assign bx_s = b ^ {W{m}};
    assign p_s  = a ^ bx_s;
    assign g_s  = a & bx_s;

    // Lookahead carries: each carry is expanded from the generate/propagate
    // terms and the carry-in alone, so no carry depends on another carry net.
    always_comb begin
        logic acc_s;
        carry_s    = '0;
        carry_s[0] = m;
        for (int i = 0; i < W; i++) begin
            acc_s = m;
            for (int j = 0; j <= i; j++) begin
                acc_s = g_s[j] | (p_s[j] & acc_s);
            end
            carry_s[i+1] = acc_s;
        end
    end

    assign s  = p_s ^ carry_s[W-1:0];
    assign co = carry_s[W];
    assign v  = carry_s[W-1] ^ carry_s[W];

endmodule

// File: rtl/addsub_arb.sv
// Two-requester round-robin arbiter in front of one shared add/sub unit,
// with a single-entry registered result stage.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   reqN_valid / reqN_ready     : request handshake per requester (N = 0, 1)
//   reqN_a, reqN_b, reqN_m      : operands and mode (0 add, 1 subtract)
//   rsp_valid / rsp_ready       : result handshake
//   rsp_id                      : requester that owns the held result
//   rsp_s, rsp_c, rsp_v         : sum, carry-out, signed overflow
module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_m,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_m,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_s,
    output logic         rsp_c,
    output logic         rsp_v
);

    state_t       state_r;
    logic         ptr_r;
    logic         rsp_valid_r;
    logic         rsp_id_r;
    logic [W-1:0] rsp_s_r;
    logic         rsp_c_r;
    logic         rsp_v_r;

    logic         can_accept_s;
    logic         gnt0_s;
    logic         gnt1_s;
    logic         accept_s;
    logic         sel_s;
    logic [W-1:0] op_a_s;
    logic [W-1:0] op_b_s;
    logic         op_m_s;
    logic [W-1:0] sum_s;
    logic         cout_s;
    logic         ovf_s;

    // Round-robin grant: a lone valid requester wins, contention goes to ptr_r.
    // Ready is forced low while reset is held so nothing is handed off then.
    always_comb begin
        can_accept_s = rst_n & ((state_r == ST_EMPTY) | rsp_ready);
        gnt0_s       = req0_valid & (~req1_valid | (ptr_r == REQ0));
        gnt1_s       = req1_valid & (~req0_valid | (ptr_r == REQ1));
        accept_s     = can_accept_s & (gnt0_s | gnt1_s);
        sel_s        = gnt1_s ? REQ1 : REQ0;
    end

    assign req0_ready = can_accept_s & gnt0_s;
    assign req1_ready = can_accept_s & gnt1_s;

    // Operand mux in front of the single shared datapath.
    always_comb begin
        if (sel_s == REQ1) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
            op_m_s = req1_m;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
            op_m_s = req0_m;
        end
    end

    addsub_cla #(
        .W (W)
    ) u_cla (
        .a  (op_a_s),
        .b  (op_b_s),
        .m  (op_m_s),
        .s  (sum_s),
        .co (cout_s),
        .v  (ovf_s)
    );

    // Result-holding FSM, round-robin pointer and registered response fields.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            ptr_r       <= REQ0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= REQ0;
            rsp_s_r     <= '0;
            rsp_c_r     <= 1'b0;
            rsp_v_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                ptr_r    <= ~sel_s;
                rsp_id_r <= sel_s;
                rsp_s_r  <= sum_s;
                rsp_c_r  <= cout_s;
                rsp_v_r  <= ovf_s;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // Drain without refill empties the stage; a refill in the
                    // same cycle keeps it full with the new result.
                    if (rsp_ready && !accept_s) begin
                        state_r     <= ST_EMPTY;
                        rsp_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_FULL;
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_s     = rsp_s_r;
    assign rsp_c     = rsp_c_r;
    assign rsp_v     = rsp_v_r;

endmodule

// File: tb/tb_addsub_arb.sv
// Directed self-checking bench for addsub_arb (W = 4).
module tb_addsub_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_m, req1_m;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_s;
    logic         rsp_c, rsp_v;

    int n_vec = 0;
    int n_err = 0;

    addsub_arb #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_c      (rsp_c),
        .rsp_v      (rsp_v)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full response bundle: {valid, id, c, v, s}.
    task automatic check_rsp(input string tag, input logic vld, input logic id,
                             input logic [W-1:0] s, input logic c, input logic v);
        check({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, vld});
        check({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
        check({tag, ".s"},     {28'd0, rsp_s},     {28'd0, s});
        check({tag, ".c"},     {31'd0, rsp_c},     {31'd0, c});
        check({tag, ".v"},     {31'd0, rsp_v},     {31'd0, v});
    endtask

    task automatic check_rdy(input string tag, input logic r0, input logic r1);
        #1;
        check({tag, ".rdy0"}, {31'd0, req0_ready}, {31'd0, r0});
        check({tag, ".rdy1"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b1;   // held during reset: ready must still be 0
        req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_m = 1'b0;
        req1_a = 4'd0; req1_b = 4'd0; req1_m = 1'b0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        check_rdy("reset", 1'b0, 1'b0);
        check_rsp("reset", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Only req0: 3 + 4 = 7; req1 operands are junk and must be ignored.
        rst_n  = 1'b1;
        req0_a = 4'd3; req0_b = 4'd4; req0_m = 1'b0;
        req1_a = 4'hF; req1_b = 4'hF; req1_m = 1'b1;
        check_rdy("r0only", 1'b1, 1'b0);
        tick();
        check_rsp("r0add", 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0);

        // Only req1, back to back: 2-5 = 1101, then 7+1 = 1000 with overflow.
        req0_valid = 1'b0;
        req0_a = 4'hA; req0_b = 4'h5; req0_m = 1'b0;
        req1_valid = 1'b1;
        req1_a = 4'd2; req1_b = 4'd5; req1_m = 1'b1;
        check_rdy("r1only", 1'b0, 1'b1);
        tick();
        check_rsp("r1sub", 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0);
        req1_a = 4'd7; req1_b = 4'd1; req1_m = 1'b0;
        tick();
        check_rsp("r1ovf", 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1);

        // Subtract with carry out, then -8 + -8 (carry and overflow).
        req1_a = 4'd5; req1_b = 4'd2; req1_m = 1'b1;
        tick();
        check_rsp("r1subc", 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0);
        req1_a = 4'h8; req1_b = 4'h8; req1_m = 1'b0;
        tick();
        check_rsp("r1neg", 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
        req1_valid = 1'b0;
        tick();
        check("drain.valid", {31'd0, rsp_valid}, 32'd0);

        // Both valid from reset: grants alternate 0,1,0,1 with one result per cycle.
        // req0: 1+1 = 2; req1: 5-2 = 3 (carry out).
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd1; req0_b = 4'd1; req0_m = 1'b0;
        req1_a = 4'd5; req1_b = 4'd2; req1_m = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_rdy($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) check_rsp($sformatf("rr%0d", i), 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
            else              check_rsp($sformatf("rr%0d", i), 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        end

        // Backpressure: result from req1 held for 3 cycles, no grants.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_rdy($sformatf("hold%0d", i), 1'b0, 1'b0);
            req1_a = 4'hC;  // changes on a stalled requester must not leak through
            tick();
            check_rsp($sformatf("hold%0d", i), 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        end
        rsp_ready = 1'b1;
        check_rdy("release", 1'b1, 1'b0);
        tick();
        check_rsp("release", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

        // Reset while FULL (pointer now 1): result discarded, pointer back to 0.
        rst_n = 1'b0;
        check_rdy("midrst", 1'b0, 1'b0);
        tick();
        check_rsp("midrst", 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        req1_a = 4'd5;
        check_rdy("postrst", 1'b1, 1'b0);
        tick();
        check_rsp("postrst", 1'b1, 1'b0, 4'd2, 1'b0, 1'b0);

        // Pointer now 1, but a lone req0 is still granted.
        req1_valid = 1'b0;
        req0_a = 4'd6; req0_b = 4'd7; req0_m = 1'b1;   // 6-7 = 1111, no carry
        check_rdy("lone0", 1'b1, 1'b0);
        tick();
        check_rsp("lone0", 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
        req0_valid = 1'b0;
        tick();
        check("end.valid", {31'd0, rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
